// File: rtl/obstacle_field.sv
// obstacle_field
//   Keeps N_OBS rectangular obstacles scrolling leftwards across the display.
//   An obstacle whose centre would reach or pass the left edge wraps back to
//   just beyond the right edge. Its new vertical centre is taken from a
//   free-running 16-bit LFSR. Every wrap is counted into a saturating score.
//
// Ports
//   i_clk      single clock for all state
//   i_rst      asynchronous active-high reset
//   i_ani_stb  one-cycle animation strobe per frame step
//   i_animate  enables motion while high
//   i_speed    pixels moved per strobe (0 freezes motion)
//   i_sel      selects the obstacle shown on the edge outputs
//   o_x1/o_x2  left/right edge of the selected obstacle (0 if i_sel >= N_OBS)
//   o_y1/o_y2  top/bottom edge of the selected obstacle (0 if i_sel >= N_OBS)
//   o_pass     registered one-cycle pulse after an update that wrapped >= 1 obstacle
//   o_score    saturating count of obstacle wraps
module obstacle_field #(
  parameter int          N_OBS    = 4,
  parameter int          H_WIDTH  = 20,
  parameter int          H_HEIGHT = 20,
  parameter int          D_WIDTH  = 640,
  parameter int          D_HEIGHT = 480,
  parameter int          SPACING  = 170,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ani_stb,
  input  logic        i_animate,
  input  logic [3:0]  i_speed,
  input  logic [2:0]  i_sel,
  output logic [11:0] o_x1,
  output logic [11:0] o_x2,
  output logic [11:0] o_y1,
  output logic [11:0] o_y2,
  output logic        o_pass,
  output logic [15:0] o_score
);

  localparam int          YRANGE = D_HEIGHT - 2 * H_HEIGHT;
  localparam logic [11:0] X_WRAP = 12'(D_WIDTH + H_WIDTH - 1);
  localparam logic [11:0] Y_MID  = 12'(D_HEIGHT / 2);

  logic [11:0] x_q [N_OBS];
  logic [11:0] x_d [N_OBS];
  logic [11:0] y_q [N_OBS];
  logic [11:0] y_d [N_OBS];
  logic [15:0] lfsr_q, lfsr_d;
  logic        pass_q, pass_d;
  logic [15:0] score_q, score_d;

  logic        update_en;
  logic [3:0]  wrap_cnt;
  logic [8:0]  r;
  logic [16:0] score_sum;
  logic        sel_valid;
  logic [11:0] sel_x, sel_y;

  assign update_en = i_ani_stb & i_animate;

  always_comb begin
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    x_d      = x_q;
    y_d      = y_q;
    wrap_cnt = '0;
    r        = '0;
    if (update_en) begin
      for (int k = 0; k < N_OBS; k++) begin
        if (x_q[k] > {8'd0, i_speed}) begin
          x_d[k] = x_q[k] - {8'd0, i_speed};
        end else if (i_speed != 4'd0) begin
          // Each obstacle takes its own 9-bit window of the current LFSR
          // value; one conditional subtract folds it into [0, YRANGE-1].
          r = 9'(lfsr_q >> k);
          if ({1'b0, r} >= 10'(YRANGE)) begin
            r = 9'({1'b0, r} - 10'(YRANGE));
          end
          x_d[k]   = X_WRAP;
          y_d[k]   = 12'(H_HEIGHT) + {3'd0, r};
          wrap_cnt = 4'(wrap_cnt + 4'd1);
        end
      end
    end
    score_sum = {1'b0, score_q} + {13'd0, wrap_cnt};
    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    pass_d    = (wrap_cnt != 4'd0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < N_OBS; k++) begin
        x_q[k] <= 12'(D_WIDTH + H_WIDTH - 1 + k * SPACING);
        y_q[k] <= Y_MID;
      end
      lfsr_q  <= SEED;
      pass_q  <= 1'b0;
      score_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      lfsr_q  <= lfsr_d;
      pass_q  <= pass_d;
      score_q <= score_d;
    end
  end

  // Output select: no match for i_sel >= N_OBS leaves sel_valid low.
  always_comb begin
    sel_valid = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    for (int k = 0; k < N_OBS; k++) begin
      if (i_sel == 3'(k)) begin
        sel_valid = 1'b1;
        sel_x     = x_q[k];
        sel_y     = y_q[k];
      end
    end
  end

  assign o_x1    = sel_valid ? sel_x - 12'(H_WIDTH)  : 12'd0;
  assign o_x2    = sel_valid ? sel_x + 12'(H_WIDTH)  : 12'd0;
  assign o_y1    = sel_valid ? sel_y - 12'(H_HEIGHT) : 12'd0;
  assign o_y2    = sel_valid ? sel_y + 12'(H_HEIGHT) : 12'd0;
  assign o_pass  = pass_q;
  assign o_score = score_q;

endmodule

// File: tb/tb_obstacle_field.sv
// tb_obstacle_field
//   Main instance with default parameters driven by directed and random
//   stimulus against an arithmetic reference model. A second small instance
//   (two coincident obstacles on a narrow display) exercises simultaneous
//   wraps and score saturation.
module tb_obstacle_field;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stb, anim;
  logic [3:0]  speed;
  logic [2:0]  sel;
  logic [11:0] x1, x2, y1, y2;
  logic        pass;
  logic [15:0] score;

  logic        s_rst, s_stb, s_anim;
  logic [3:0]  s_speed;
  logic [2:0]  s_sel;
  logic [11:0] s_x1, s_x2, s_y1, s_y2;
  logic        s_pass;
  logic [15:0] s_score;

  obstacle_field dut (
    .i_clk(clk), .i_rst(rst), .i_ani_stb(stb), .i_animate(anim),
    .i_speed(speed), .i_sel(sel),
    .o_x1(x1), .o_x2(x2), .o_y1(y1), .o_y2(y2),
    .o_pass(pass), .o_score(score)
  );

  obstacle_field #(.N_OBS(2), .H_WIDTH(1), .D_WIDTH(8), .SPACING(0)) dut_sat (
    .i_clk(clk), .i_rst(s_rst), .i_ani_stb(s_stb), .i_animate(s_anim),
    .i_speed(s_speed), .i_sel(s_sel),
    .o_x1(s_x1), .o_x2(s_x2), .o_y1(s_y1), .o_y2(s_y2),
    .o_pass(s_pass), .o_score(s_score)
  );

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;
  bit chk_main = 1'b1;
  bit chk_sat  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int mx[4], my[4];
  int ml, mscore;
  bit mpass;
  int sx[2];
  int sscore;
  bit spass;

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 16'hFFFF;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mx[k] = 659 + k * 170;
      my[k] = 240;
    end
    ml = 16'hACE1; mscore = 0; mpass = 1'b0;
  endtask

  task automatic sat_reset();
    sx[0] = 8; sx[1] = 8; sscore = 0; spass = 1'b0;
  endtask

  task automatic model_step();
    int w, r;
    w = 0;
    if (stb && anim) begin
      for (int k = 0; k < 4; k++) begin
        if (mx[k] > int'(speed)) mx[k] -= int'(speed);
        else if (speed != 0) begin
          r = (ml >> k) & 511;
          if (r >= 440) r -= 440;
          my[k] = 20 + r;
          mx[k] = 659;
          w++;
        end
      end
    end
    mpass  = (w > 0);
    mscore = (mscore + w > 65535) ? 65535 : mscore + w;
    ml     = lfsr_next(ml);
  endtask

  task automatic sat_step();
    int w;
    w = 0;
    if (s_stb && s_anim) begin
      for (int k = 0; k < 2; k++) begin
        if (sx[k] > int'(s_speed)) sx[k] -= int'(s_speed);
        else if (s_speed != 0) begin
          sx[k] = 8;
          w++;
        end
      end
    end
    spass  = (w > 0);
    sscore = (sscore + w > 65535) ? 65535 : sscore + w;
  endtask

  task automatic check_all();
    int ex1, ex2, ey1, ey2;
    if (chk_main) begin
      if (sel < 4) begin
        ex1 = (mx[sel] - 20) & 12'hFFF; ex2 = (mx[sel] + 20) & 12'hFFF;
        ey1 = (my[sel] - 20) & 12'hFFF; ey2 = (my[sel] + 20) & 12'hFFF;
      end else begin
        ex1 = 0; ex2 = 0; ey1 = 0; ey2 = 0;
      end
      check_eq("x1", 32'(x1), ex1);
      check_eq("x2", 32'(x2), ex2);
      check_eq("y1", 32'(y1), ey1);
      check_eq("y2", 32'(y2), ey2);
      check_eq("pass", 32'(pass), 32'(mpass));
      check_eq("score", 32'(score), mscore);
    end
    if (chk_sat) begin
      check_eq("sat_pass", 32'(s_pass), 32'(spass));
      check_eq("sat_score", 32'(s_score), sscore);
    end
  endtask

  // One clock: advance both models with the inputs now applied, then
  // sample at the following falling edge.
  task automatic tick();
    model_step();
    sat_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // ---------------- driver / test sequence ----------------
  int rst_x1[4] = '{639, 809, 979, 1149};
  int saved_score;

  initial begin
    rst = 1'b1; stb = 1'b0; anim = 1'b0; speed = 4'd0; sel = 3'd0;
    s_rst = 1'b1; s_stb = 1'b0; s_anim = 1'b1; s_speed = 4'd0; s_sel = 3'd0;
    model_reset();
    sat_reset();
    @(posedge clk);
    @(negedge clk);

    // reset defaults
    for (int i = 0; i < 4; i++) begin
      sel = 3'(i);
      #1;
      check_eq("rst_x1", 32'(x1), rst_x1[i]);
      check_eq("rst_y1", 32'(y1), 220);
    end
    sel = 3'd5;
    #1;
    check_eq("rst_sel5", {x1, y1[7:0]} | {8'd0, x2, y2}, 0);
    check_eq("rst_score", 32'(score), 0);
    check_eq("sat_rst_x1", 32'(s_x1), 7);
    check_eq("sat_rst_x2", 32'(s_x2), 9);
    sel = 3'd0;
    @(negedge clk);
    rst = 1'b0; s_rst = 1'b0;

    // steady motion
    speed = 4'd3; anim = 1'b1;
    for (int i = 0; i < 10; i++) begin
      stb = 1'b1; tick();
      stb = 1'b0; tick();
    end
    check_eq("steady_x1", 32'(x1), 609);
    anim = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stb = 1'b1; tick();
      stb = 1'b0; tick();
    end
    check_eq("frozen_x1", 32'(x1), 609);

    // drive x[0] down to 2, then wrap it
    anim = 1'b1; stb = 1'b1;
    for (int i = 0; i < 209; i++) tick();
    check_eq("near_edge_x1", 32'(x1), 4078);
    check_eq("near_edge_score", 32'(score), 0);
    tick();
    check_eq("wrap_x1", 32'(x1), 639);
    check_eq("wrap_pass", 32'(pass), 1);
    check_eq("wrap_score", 32'(score), 1);
    check_eq("wrap_y_range", 32'((y1 + 20 >= 20) && (y1 + 20 <= 459)), 1);
    stb = 1'b0;
    tick();
    check_eq("wrap_pass_drop", 32'(pass), 0);

    // speed 0 freezes everything
    saved_score = mscore;
    speed = 4'd0; stb = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    check_eq("speed0_x1", 32'(x1), 639);
    check_eq("speed0_score", 32'(score), saved_score);
    stb = 1'b0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      stb   = 1'($urandom_range(0, 1));
      anim  = ($urandom_range(0, 3) != 0);
      speed = 4'($urandom_range(0, 15));
      sel   = 3'($urandom_range(0, 7));
      tick();
    end
    stb = 1'b0;

    // simultaneous wrap on the small instance
    chk_sat = 1'b1;
    s_speed = 4'd1; s_stb = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check_eq("simul_pre_score", 32'(s_score), 0);
    tick();
    check_eq("simul_pass", 32'(s_pass), 1);
    check_eq("simul_score", 32'(s_score), 2);
    s_stb = 1'b0;
    tick();
    check_eq("simul_pass_drop", 32'(s_pass), 0);

    // run the score up to saturation
    chk_main = 1'b0; chk_sat = 1'b0;
    s_speed = 4'd15; s_stb = 1'b1;
    while (sscore < 65520) tick();
    chk_sat = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check_eq("sat_final", 32'(s_score), 65535);
    s_stb = 1'b0;
    chk_main = 1'b1;

    // asynchronous reset between clock edges, mid-run
    sel = 3'd0; anim = 1'b1; speed = 4'd5; stb = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    model_step();
    sat_step();
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_eq("async_x1", 32'(x1), 639);
    check_eq("async_y1", 32'(y1), 220);
    check_eq("async_score", 32'(score), 0);
    check_eq("async_pass", 32'(pass), 0);

    // reset held across a strobe edge: no update may slip through
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      stb   = 1'($urandom_range(0, 1));
      speed = 4'($urandom_range(1, 15));
      sel   = 3'($urandom_range(0, 7));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/obstacle_field.md
OBSTACLE_FIELD -- requirements
Module: obstacle_field

Interface
REQ-001 SHALL have parameter N_OBS, default 4, number of obstacles, legal range 1-8.
REQ-002 SHALL have parameter H_WIDTH, default 20, half obstacle width in pixels.
REQ-003 SHALL have parameter H_HEIGHT, default 20, half obstacle height in pixels.
REQ-004 SHALL have parameters D_WIDTH and D_HEIGHT, defaults 640 and 480, display size in pixels.
REQ-005 SHALL have parameter SPACING, default 170, initial horizontal gap between obstacle centres.
REQ-006 SHALL have parameter SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-007 SHALL have port i_clk, input, 1 bit, the single clock for all state.
REQ-008 SHALL have port i_rst, input, 1 bit, asynchronous active-high reset.
REQ-009 SHALL have port i_ani_stb, input, 1 bit, animation strobe with one-cycle pulse per frame step.
REQ-010 SHALL have port i_animate, input, 1 bit, which enables motion when high.
REQ-011 SHALL have port i_speed, input, 4 bits, pixels moved per strobe; 0 freezes motion.
REQ-012 SHALL have port i_sel, input, 3 bits, index of the obstacle driven on the edge outputs.
REQ-013 SHALL have ports o_x1, o_x2, o_y1 and o_y2, outputs, 12 bits each, giving the left, right, top and bottom edges of the selected obstacle.
REQ-014 SHALL have port o_pass, output, 1 bit, a one-cycle pulse when any obstacle wraps.
REQ-015 SHALL have port o_score, output, 16 bits, the running count of obstacle wraps.

Function
REQ-016 SHALL hold a 12-bit centre x[k] and a 12-bit centre y[k] for each obstacle k = 0..N_OBS-1.
REQ-017 SHALL require D_WIDTH+H_WIDTH-1+(N_OBS-1)*SPACING <= 4095 and 256 <= YRANGE <= 512, where YRANGE = D_HEIGHT-2*H_HEIGHT.
REQ-018 SHALL update obstacle state only on i_clk edges where i_ani_stb=1 and i_animate=1; all other edges hold state.
REQ-019 SHALL, on an update edge, set x[k] to x[k]-i_speed when x[k] > i_speed.
REQ-020 SHALL, on an update edge with x[k] <= i_speed and i_speed != 0, wrap the obstacle: x[k] = D_WIDTH+H_WIDTH-1 and y[k] = H_HEIGHT+r'.
REQ-021 SHALL take r = lfsr[k+8:k] (9 bits) and set r' = r-YRANGE if r >= YRANGE, else r' = r, so that y[k] lies in [H_HEIGHT, D_HEIGHT-H_HEIGHT-1].
REQ-022 SHALL use a 16-bit Fibonacci LFSR that shifts left every i_clk cycle, with new bit0 = b15^b13^b12^b10.
REQ-023 SHALL let several obstacles wrap on the same edge, each taking its own slice of the same LFSR value.
REQ-024 SHALL register o_pass high for exactly the one cycle after an update edge in which at least one obstacle wrapped.
REQ-025 SHALL, on that same edge, add the number of wrapping obstacles to o_score, saturating at 16'hFFFF.
REQ-026 SHALL drive the edge outputs combinationally from the selected registers: o_x1=x-H_WIDTH, o_x2=x+H_WIDTH, o_y1=y-H_HEIGHT, o_y2=y+H_HEIGHT, all modulo 4096.
REQ-027 SHALL drive all four edge outputs to 0 when i_sel >= N_OBS.
REQ-028 SHALL leave positions and score unchanged, and pulse o_pass 0, when i_speed=0.

Reset
REQ-029 SHALL, while i_rst=1 and independent of i_clk, set x[k] = D_WIDTH+H_WIDTH-1+k*SPACING, y[k] = D_HEIGHT/2, lfsr = SEED, o_pass = 0 and o_score = 0.
REQ-030 SHALL, when reset is asserted mid-motion or coincident with a strobe, apply the reset values with no partial update or wrap counted.

Verification
REQ-031 SHALL cover reset defaults: after reset, i_sel=0..3 gives o_x1 = 639/809/979/1149 and o_y1 = 220; i_sel=5 gives all edges 0; o_score = 0.
REQ-032 SHALL cover steady motion: i_speed=3, 10 strobes with i_animate=1 -> x[0] = 629 (o_x1 = 609); with i_animate=0, 10 more strobes -> unchanged.
REQ-033 SHALL cover wrap: x[0] driven to 2, i_speed=3, one strobe -> x[0] = 659, y[0] in [20,459] matching the reference LFSR model, o_pass high for one cycle, o_score +1.
REQ-034 SHALL cover simultaneous wrap: x[0] = x[1] = 1 at speed 1 -> both wrap on one strobe, o_score +2, single o_pass pulse.
REQ-035 SHALL cover boundaries: o_score preset near 16'hFFFF saturates with no rollover; i_speed=0 for 100 strobes gives no change.
REQ-036 SHALL cover asynchronous reset: i_rst pulsed between clock edges mid-run -> outputs return to reset values before the next i_clk edge.
